// File: rtl/loan_uart_pkg.sv
// loan_uart_pkg
// Shared types and helpers for the loan-IO UART controller.
//   rx_state_t / tx_state_t : receiver and transmitter FSM encodings
//   calc_div                : clocks per bit, rounded to nearest
//   LOAN_RX_PIN/LOAN_TX_PIN : default loan-IO indices for UART RX/TX
package loan_uart_pkg;

  localparam int LOAN_RX_PIN = 49;
  localparam int LOAN_TX_PIN = 50;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/loan_io_uart_ctrl_rx.sv
// loan_io_uart_ctrl_rx
// 8N1 UART receiver: 2-flop synchroniser, bit-timing FSM, output
// register with valid/ready handshake, sticky overrun and frame error pulse.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   rx_pin          : asynchronous serial input
//   rx_data/valid   : received byte, held until rx_ready
//   rx_ready        : consumer accepts rx_data
//   rx_overrun      : sticky, a byte was dropped while rx_valid pending
//   frame_err       : one-cycle pulse on a bad stop bit
//
// state        | meaning
// -------------+---------------------------------------------
// RX_IDLE      | line high, waiting for a falling edge
// RX_START     | timing to mid start bit, reject glitches
// RX_DATA      | sampling 8 data bits, LSB first
// RX_STOP      | sampling stop bit, deliver or flag error
// RX_WAIT_HIGH | bad frame, wait for line to return high
module loan_io_uart_ctrl_rx
  import loan_uart_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((DIV >= 2) ? (DIV / 2 - 1) : 0);

  logic             sync_1, sync_2;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_d;
  logic             valid_d, overrun_d, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= rx_pin;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data    <= data_d;
      rx_valid   <= valid_d;
      rx_overrun <= overrun_d;
      frame_err  <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = rx_data;
    valid_d   = rx_valid & ~rx_ready;
    overrun_d = rx_overrun;
    ferr_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync_2) begin
          state_d = RX_START;
          cnt_d   = HALF;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sync_2) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          cnt_d   = FULL;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {sync_2, shift_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sync_2) begin
          state_d = RX_IDLE;
          // An accept in this same cycle frees the register for the new byte.
          if (rx_valid && !rx_ready) begin
            overrun_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          ferr_d  = 1'b1;
          state_d = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (sync_2) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/loan_io_uart_ctrl.sv
// loan_io_uart_ctrl
// 8N1 UART over HPS loan-IO pins: RX on loan_in[RX_PIN], TX on
// loan_out[TX_PIN]. Drives the full loan-IO out/oe vectors.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   loan_in/out/oe      : h2f loan-IO vectors
//   tx_data/valid/ready : host-bound byte stream
//   rx_data/valid/ready : fabric-bound byte stream
//   rx_overrun          : sticky dropped-byte flag
//   frame_err           : one-cycle bad stop bit pulse
// Build option: LOAN_UART_LOOPBACK_EN feeds the TX line back into the
// receiver internally, releases all pads (oe = 0) and parks TX high.
//
// state    | meaning
// ---------+-----------------------------------
// TX_IDLE  | line high, tx_ready asserted
// TX_START | driving start bit (0)
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit (1)
module loan_io_uart_ctrl
  import loan_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int RX_PIN = LOAN_RX_PIN,
  parameter int TX_PIN = LOAN_TX_PIN,
  parameter int LOAN_W = 67
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LOAN_W-1:0] loan_in,
  output logic [LOAN_W-1:0] loan_out,
  output logic [LOAN_W-1:0] loan_oe,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              frame_err
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             rx_src;
  logic             unused_loan_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_ready   = (tx_state_q == TX_IDLE);
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_line_d  = 1'b0;
          tx_cnt_d   = FULL;
          tx_shift_d = tx_data;
          tx_bit_d   = '0;
        end
      end
      TX_START: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_state_d = TX_DATA;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_cnt_d   = FULL;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end else begin
          tx_cnt_d = FULL;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q != '0) tx_cnt_d   = tx_cnt_q - 1'b1;
        else                tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Only loan_in[RX_PIN] is functional; the rest is deliberately ignored.
  assign unused_loan_in = ^loan_in;

`ifdef LOAN_UART_LOOPBACK_EN
  assign rx_src = tx_line_q;
  always_comb begin
    loan_oe          = '0;
    loan_out         = '0;
    loan_out[TX_PIN] = 1'b1;
  end
`else
  assign rx_src = loan_in[RX_PIN];
  always_comb begin
    loan_oe          = '0;
    loan_oe[TX_PIN]  = 1'b1;
    loan_out         = '0;
    loan_out[TX_PIN] = tx_line_q;
  end
`endif

  loan_io_uart_ctrl_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_pin     (rx_src),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err)
  );

endmodule

// File: tb/tb_loan_io_uart_ctrl.sv
// tb_loan_io_uart_ctrl
// Directed bench with scoreboard queues: stimulus pushes expected RX and
// TX bytes, independent monitors pop and compare when the DUT presents them.
// Build with LOAN_UART_LOOPBACK_EN defined to exercise the loopback option.
module tb_loan_io_uart_ctrl;

  localparam int LOAN_W = 67;
  localparam logic [LOAN_W-1:0] TX_BIT = 67'd1 << 50;

  logic              clk = 1'b0;
  logic              reset;
  logic [LOAN_W-1:0] loan_in;
  logic [LOAN_W-1:0] loan_out;
  logic [LOAN_W-1:0] loan_oe;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic              frame_err;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ferr_w   = 0;
  logic rx_valid_prev = 1'b0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];

  always #5 clk = ~clk;

  loan_io_uart_ctrl #(
    .CLK_HZ(1000000),
    .BAUD  (100000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .loan_in    (loan_in),
    .loan_out   (loan_out),
    .loan_oe    (loan_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RX byte monitor and frame_err pulse-width monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && !rx_valid_prev) begin
        if (rx_exp_q.size() == 0) begin
          chk("rx_unexpected_byte", {8'h1, rx_data}, 16'h0);
        end else begin
          chk("rx_byte", rx_data, rx_exp_q.pop_front());
        end
      end
      if (frame_err) begin
        ferr_w++;
      end else if (ferr_w != 0) begin
        ferr_cnt++;
        chk("frame_err_width", ferr_w, 1);
        ferr_w = 0;
      end
    end
    rx_valid_prev = rx_valid;
  end

  // TX line monitor: decodes loan_out[50] as an independent UART receiver.
  initial begin
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (!reset && !loan_out[50]) begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          repeat (10) @(negedge clk);
          got[i] = loan_out[50];
        end
        if (tx_exp_q.size() == 0) chk("tx_unexpected_frame", {1'b1, got}, 10'h0);
        else                      chk("tx_frame", got, {1'b1, tx_exp_q.pop_front()});
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      loan_in[49] = frame[i];
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    tx_exp_q.push_back(b);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
  endtask

  initial begin
    reset    = 1'b1;
    loan_in  = '0;
    loan_in[49] = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);

`ifdef LOAN_UART_LOOPBACK_EN
    chk("lb_reset_oe", loan_oe, 67'd0);
    chk("lb_reset_out", loan_out, TX_BIT);
    chk("lb_reset_tx_ready", tx_ready, 1'b1);
    chk("lb_reset_rx_valid", rx_valid, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    rx_exp_q.push_back(8'hC3);
    send_tx(8'hC3);
    tx_exp_q.delete();
    begin
      int n;
      n = 0;
      while (!rx_valid && n < 104) begin
        @(negedge clk);
        n++;
        if (n == 50) chk("lb_mid_out", loan_out, TX_BIT);
      end
      chk("lb_rx_valid_in_time", rx_valid, 1'b1);
    end
    chk("lb_rx_data", rx_data, 8'hC3);
    chk("lb_oe_held", loan_oe, 67'd0);
    repeat (20) @(negedge clk);
    chk("lb_frame_err_none", ferr_cnt, 0);
`else
    chk("reset_oe", loan_oe, TX_BIT);
    chk("reset_out", loan_out, TX_BIT);
    chk("reset_tx_ready", tx_ready, 1'b1);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_flags", {rx_overrun, frame_err}, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", {loan_oe, loan_out, tx_ready, rx_valid, rx_data, rx_overrun, frame_err},
          {TX_BIT, TX_BIT, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    end

    // TX 0xA5: exact bit-level waveform, tx_data changed after accept.
    begin
      logic [9:0] exp_bits;
      exp_bits = {1'b1, 8'hA5, 1'b0};
      send_tx(8'hA5);
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk($sformatf("tx_line_bit%0d_c%0d", b, c), loan_out[50], exp_bits[b]);
        end
      end
      chk("tx_ready_busy_last", tx_ready, 1'b0);
      @(negedge clk);
      chk("tx_ready_back", tx_ready, 1'b1);
      chk("tx_idle_line", loan_out, TX_BIT);
    end

    // RX 0x3C held, then 0x81 overruns.
    repeat (5) @(negedge clk);
    rx_exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    chk("rx1_valid", rx_valid, 1'b1);
    chk("rx1_data", rx_data, 8'h3C);
    chk("rx1_no_overrun", rx_overrun, 1'b0);
    send_rx(8'h81, 1'b1);
    repeat (2) @(negedge clk);
    chk("ovr_flag", rx_overrun, 1'b1);
    chk("ovr_data_kept", rx_data, 8'h3C);
    chk("ovr_valid_kept", rx_valid, 1'b1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("accept_clears_valid", rx_valid, 1'b0);
    chk("ovr_sticky", rx_overrun, 1'b1);

    // Bad stop bit, line then held low long enough to expose a restart.
    repeat (5) @(negedge clk);
    send_rx(8'h55, 1'b0);
    repeat (120) @(negedge clk);
    chk("ferr_once_while_low", ferr_cnt, 1);
    loan_in[49] = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_no_valid", rx_valid, 1'b0);

    // 3-cycle glitch must be rejected.
    loan_in[49] = 1'b0;
    repeat (3) @(negedge clk);
    loan_in[49] = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_valid", rx_valid, 1'b0);
    chk("glitch_no_ferr", ferr_cnt, 1);

    rx_ready = 1'b1;
    rx_exp_q.push_back(8'h12);
    send_rx(8'h12, 1'b1);
    repeat (5) @(negedge clk);
    chk("rx2_data", rx_data, 8'h12);
    chk("rx2_no_ferr", ferr_cnt, 1);
`endif

    chk("rx_queue_drained", rx_exp_q.size(), 0);
    chk("tx_queue_drained", tx_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
